branch_resolve_unit: RTL and testbench

//  Registered branch/jump resolution stage for the scoreboard MIPS core.

---
 rtl/bru_pkg.sv | 17 +
 rtl/bru_target_calc.sv | 73 +++++++
 rtl/branch_resolve_unit.sv | 128 ++++++++++++
 tb/tb_branch_resolve_unit.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bru_pkg.sv
// Shared decode constants and FSM state type for the branch resolve unit.
// Imported by bru_target_calc and branch_resolve_unit.
package bru_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] FN_JR    = 6'b001000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REDIR = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/bru_target_calc.sv
// Combinational decode of one control-transfer instruction: taken decision and target PC.
// The is_branch output exists only when BRU_PERF_CNT_EN is defined.
module bru_target_calc
  import bru_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     ir,
  input  logic [XLEN-1:0] pc4,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            taken,
  output logic [XLEN-1:0] target
`ifdef BRU_PERF_CNT_EN
  ,
  output logic            is_branch
`endif
);

  logic [5:0]      opcode;
  logic [5:0]      funct;
  logic [XLEN-1:0] br_off;
  logic [XLEN-1:0] j_target;
  logic            operands_eq;
  logic            cond_branch;

  assign opcode      = ir[31:26];
  assign funct       = ir[5:0];
  // Sign-extended word offset; the add below wraps modulo 2^XLEN.
  assign br_off      = {{(XLEN-18){ir[15]}}, ir[15:0], 2'b00};
  assign j_target    = {pc4[XLEN-1:28], ir[25:0], 2'b00};
  assign operands_eq = (a == b);

  // NOTE: every output of a combinational block gets a default before the case,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    taken       = 1'b0;
    target      = '0;
    cond_branch = 1'b0;
    case (opcode)
      OP_J: begin
        taken  = 1'b1;
        target = j_target;
      end
      OP_BEQ: begin
        cond_branch = 1'b1;
        taken       = operands_eq;
        target      = pc4 + br_off;
      end
      OP_BNE: begin
        cond_branch = 1'b1;
        taken       = !operands_eq;
        target      = pc4 + br_off;
      end
      OP_RTYPE: begin
        if (funct == FN_JR) begin
          taken  = 1'b1;
          target = a;
        end
      end
      default: ;
    endcase
  end

`ifdef BRU_PERF_CNT_EN
  assign is_branch = cond_branch;
`else
  // Only consumed by the perf counters; keep the decode visible for debug.
  logic unused_cond_branch;
  assign unused_cond_branch = cond_branch;
`endif

endmodule

// File: rtl/branch_resolve_unit.sv
// Registered branch/jump resolution stage: decide, redirect fetch, then hold flush.
// Define BRU_PERF_CNT_EN to add saturating taken_cnt/ntaken_cnt performance counters.
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2
`ifdef BRU_PERF_CNT_EN
  ,
  parameter int CNT_W        = 16
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_ir,
  input  logic [XLEN-1:0] in_pc4,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic            redir_valid,
  input  logic            redir_ready,
  output logic [XLEN-1:0] redir_pc,
  output logic            flush
`ifdef BRU_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] ntaken_cnt
`endif
);

  localparam int FC_LOAD = (FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0;
  localparam int FC_W    = (FC_LOAD > 0) ? $clog2(FC_LOAD + 1) : 1;

  state_t          state, state_nxt;
  logic [FC_W-1:0] flush_cnt, flush_cnt_nxt;
  logic [XLEN-1:0] redir_pc_nxt;
  logic            accept;
  logic            res_taken;
  logic [XLEN-1:0] res_target;
`ifdef BRU_PERF_CNT_EN
  logic            res_is_branch;
`endif

  bru_target_calc #(
    .XLEN(XLEN)
  ) u_target_calc (
    .ir       (in_ir),
    .pc4      (in_pc4),
    .a        (in_a),
    .b        (in_b),
    .taken    (res_taken),
    .target   (res_target)
`ifdef BRU_PERF_CNT_EN
    ,
    .is_branch(res_is_branch)
`endif
  );

  // Outputs decode straight from the registered state, so an async reset clears them at once.
  assign in_ready    = (state == ST_IDLE);
  assign redir_valid = (state == ST_REDIR);
  assign flush       = (state == ST_FLUSH);
  assign accept      = in_valid && in_ready;

  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    redir_pc_nxt  = redir_pc;
    case (state)
      ST_IDLE: begin
        if (accept && res_taken) begin
          redir_pc_nxt = res_target;
          state_nxt    = ST_REDIR;
        end
      end
      ST_REDIR: begin
        if (redir_ready) begin
          if (FLUSH_CYCLES == 0) begin
            state_nxt = ST_IDLE;
          end else begin
            state_nxt     = ST_FLUSH;
            flush_cnt_nxt = FC_W'(FC_LOAD);
          end
        end
      end
      ST_FLUSH: begin
        // The counter holds the flush cycles remaining after the current one.
        if (flush_cnt == '0) begin
          state_nxt = ST_IDLE;
        end else begin
          flush_cnt_nxt = flush_cnt - FC_W'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      flush_cnt <= '0;
      redir_pc  <= '0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
      redir_pc  <= redir_pc_nxt;
    end
  end

`ifdef BRU_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken_cnt  <= '0;
      ntaken_cnt <= '0;
    end else if (accept) begin
      if (res_taken) begin
        if (taken_cnt != '1) taken_cnt <= taken_cnt + CNT_W'(1);
      end else if (res_is_branch) begin
        if (ntaken_cnt != '1) ntaken_cnt <= ntaken_cnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed scenarios then randomized traffic.
// Honours BRU_PERF_CNT_EN (counters with CNT_W=2) and the TB_FLUSH_CYCLES parameter.
`timescale 1ns/1ps
module tb_branch_resolve_unit #(
  parameter int TB_FLUSH_CYCLES = 2
);

  localparam int XLEN = 32;
  localparam int FLUSH_CYCLES = TB_FLUSH_CYCLES;
`ifdef BRU_PERF_CNT_EN
  localparam int CNT_W = 2;
  logic [CNT_W-1:0] taken_cnt, ntaken_cnt;
`endif

  logic            clk, rst_n;
  logic            in_valid, in_ready;
  logic [31:0]     in_ir;
  logic [XLEN-1:0] in_pc4, in_a, in_b;
  logic            redir_valid, redir_ready;
  logic [XLEN-1:0] redir_pc;
  logic            flush;

  branch_resolve_unit #(
    .XLEN(XLEN),
    .FLUSH_CYCLES(FLUSH_CYCLES)
`ifdef BRU_PERF_CNT_EN
    ,
    .CNT_W(CNT_W)
`endif
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_ir      (in_ir),
    .in_pc4     (in_pc4),
    .in_a       (in_a),
    .in_b       (in_b),
    .redir_valid(redir_valid),
    .redir_ready(redir_ready),
    .redir_pc   (redir_pc),
    .flush      (flush)
`ifdef BRU_PERF_CNT_EN
    ,
    .taken_cnt  (taken_cnt),
    .ntaken_cnt (ntaken_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural meaning of J/BEQ/BNE/JR in plain arithmetic.
  function automatic void model(input logic [31:0] ir, input logic [31:0] pc4,
                                input logic [31:0] a, input logic [31:0] b,
                                output bit taken, output bit is_br, output logic [31:0] tgt);
    longint off;
    taken = 0;
    is_br = 0;
    tgt   = '0;
    off   = longint'($signed(ir[15:0])) * 4;
    case (ir[31:26])
      6'd2: begin
        taken = 1;
        tgt   = (pc4 & 32'hF000_0000) | ({6'd0, ir[25:0]} * 32'd4);
      end
      6'd4, 6'd5: begin
        is_br = 1;
        taken = (ir[31:26] == 6'd4) ? (a == b) : (a != b);
        tgt   = 32'(longint'(pc4) + off);
      end
      6'd0: begin
        if (ir[5:0] == 6'd8) begin
          taken = 1;
          tgt   = a;
        end
      end
      default: ;
    endcase
  endfunction

  function automatic int sat(input int n, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (n > mx) ? mx : n;
  endfunction

  logic [31:0] exp_q[$];
  bit          last_taken, last_is_br;
  int          rr_mode;   // 0: ready high, 1: random, 2: held low

  // redir_ready driver, updated mid-cycle so main-thread mode changes land first.
  initial begin
    redir_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (rr_mode)
        0:       redir_ready = 1'b1;
        1:       redir_ready = 1'($urandom_range(0, 1));
        default: redir_ready = 1'b0;
      endcase
    end
  end

  task automatic send(input logic [31:0] ir, input logic [31:0] pc4,
                      input logic [31:0] a, input logic [31:0] b);
    bit t, br;
    logic [31:0] tg;
    int guard;
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (!in_ready) begin
      check("send_timeout", in_ready, 1);
      return;
    end
    model(ir, pc4, a, b, t, br, tg);
    if (t) exp_q.push_back(tg);
    last_taken = t;
    last_is_br = br;
    in_valid   = 1'b1;
    in_ir      = ir;
    in_pc4     = pc4;
    in_a       = a;
    in_b       = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (!in_ready) check("idle_timeout", in_ready, 1);
  endtask

  // Monitor / scoreboard
  bit          pend, pend_taken, hold, flush_start, prev_flush;
  logic [31:0] hold_pc;
  int          run, m_taken, m_ntaken;

  always @(negedge clk) begin
    if (!rst_n) begin
      pend = 0; hold = 0; flush_start = 0; prev_flush = 0; run = 0;
      m_taken = 0; m_ntaken = 0;
      exp_q.delete();
    end else begin
`ifdef BRU_PERF_CNT_EN
      check("taken_cnt", taken_cnt, sat(m_taken, CNT_W));
      check("ntaken_cnt", ntaken_cnt, sat(m_ntaken, CNT_W));
`endif
      if (pend) begin
        check("redir_latency", redir_valid, pend_taken);
        if (!pend_taken) check("ready_after_ntaken", in_ready, 1);
        pend = 0;
      end
      if (hold) begin
        check("redir_hold_valid", redir_valid, 1);
        check("redir_hold_pc", redir_pc, hold_pc);
        hold = 0;
      end
      if (flush_start) begin
        check("flush_start", flush, (FLUSH_CYCLES > 0));
        flush_start = 0;
      end
      if (flush) begin
        run++;
      end else if (prev_flush) begin
        check("flush_len", run, FLUSH_CYCLES);
        run = 0;
      end
      prev_flush = flush;
      check("in_ready_state", in_ready, !redir_valid && !flush);
      if (redir_valid && redir_ready) begin
        if (exp_q.size() == 0) check("unexpected_redir", redir_valid, 0);
        else check("redir_pc", redir_pc, exp_q.pop_front());
        flush_start = 1;
      end else if (redir_valid) begin
        hold    = 1;
        hold_pc = redir_pc;
      end
      if (in_valid && in_ready) begin
        pend       = 1;
        pend_taken = last_taken;
        if (last_taken) m_taken++;
        else if (last_is_br) m_ntaken++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ir, pc4, a, b;
    int kind, guard;
    rst_n = 1'b0; in_valid = 1'b0; in_ir = '0; in_pc4 = '0; in_a = '0; in_b = '0;
    rr_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_redir_valid", redir_valid, 0);
    check("rst_redir_pc", redir_pc, 0);
    check("rst_flush", flush, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: taken BEQ, one-cycle REDIR, flush checked by monitor
    send({6'd4, 5'd1, 5'd2, 16'h0003}, 32'h100, 32'd5, 32'd5);
    check("t1_valid", redir_valid, 1);
    check("t1_pc", redir_pc, 32'h10C);
    wait_idle();

    // 2: not-taken BNE then taken BNE back-to-back, backward target
    send({6'd5, 5'd1, 5'd2, 16'hFFFF}, 32'h200, 32'd7, 32'd7);
    check("t2_ready", in_ready, 1);
    check("t2_no_redir", redir_valid, 0);
    send({6'd5, 5'd1, 5'd2, 16'hFFFF}, 32'h200, 32'd1, 32'd2);
    check("t2_pc", redir_pc, 32'h1FC);
    wait_idle();

    // 3: J with fetch stalled for 3 cycles
    rr_mode = 2;
    send({6'd2, 26'h0000040}, 32'h9000_0004, 32'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("t3_valid", redir_valid, 1);
      check("t3_pc", redir_pc, 32'h9000_0100);
      check("t3_ready", in_ready, 0);
      @(posedge clk);
      #1;
    end
    rr_mode = 0;
    wait_idle();

    // 4: JR, then reset during flush
    send({6'd0, 5'd4, 15'd0, 6'd8}, 32'h1000, 32'h0040_0020, 32'd0);
    check("t4_pc", redir_pc, 32'h0040_0020);
    guard = 0;
    while (!flush && !in_ready && guard < 50) begin
      @(posedge clk);
      #1;
      guard++;
    end
    rst_n = 1'b0;
    #1;
    check("t4_rst_flush", flush, 0);
    check("t4_rst_ready", in_ready, 1);
    check("t4_rst_valid", redir_valid, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Randomized traffic with random fetch backpressure
    rr_mode = 1;
    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 5);
      pc4  = $urandom & 32'hFFFF_FFFC;
      a    = $urandom;
      b    = ($urandom_range(0, 1) == 1) ? a : 32'($urandom);
      case (kind)
        0: ir = {6'd2, 26'($urandom)};
        1: ir = {6'd4, 26'($urandom)};
        2: ir = {6'd5, 26'($urandom)};
        3: ir = {6'd0, 20'($urandom), 6'd8};
        4: ir = {6'd0, 20'($urandom), 6'h20};
        default: begin
          ir = $urandom;
          while (ir[31:26] inside {6'd0, 6'd2, 6'd4, 6'd5}) ir = $urandom;
        end
      endcase
      send(ir, pc4, a, b);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    rr_mode = 0;
    wait_idle();
    repeat (FLUSH_CYCLES + 3) @(posedge clk);
    #1;

`ifdef BRU_PERF_CNT_EN
    // 6: saturation with CNT_W=2, not-taken branch, non-control no-op
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      send({6'd2, 26'($urandom)}, 32'h0000_1000, 32'd0, 32'd0);
      wait_idle();
    end
    check("t6_taken_sat", taken_cnt, 3);
    send({6'd4, 10'd0, 16'h0010}, 32'h400, 32'd1, 32'd2);
    send({6'd0, 20'd0, 6'h20}, 32'h400, 32'd1, 32'd1);
    @(posedge clk);
    #1;
    check("t6_taken_hold", taken_cnt, 3);
    check("t6_ntaken", ntaken_cnt, 1);
`endif

    check("exp_q_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
